// File: rtl/countdown_display_pkg.sv
// Shared constants and types for the countdown display controller.
package countdown_display_pkg;

   // Codes driven by the game controller on game_state.
   localparam logic [7:0] GS_IDLE     = 8'h00;
   localparam logic [7:0] GS_ARMED    = 8'h10;
   localparam logic [7:0] GS_DEFUSED  = 8'h20;
   localparam logic [7:0] GS_EXPLODED = 8'h30;

   // Display FSM states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_WARN    = 3'd2,
      ST_EXPIRED = 3'd3,
      ST_DEFUSED = 3'd4
   } state_t;

   // Active-low segment patterns {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam int BLINK_W = 24;

   // True when all three time digits read zero.
   function automatic logic digits_zero(input logic [3:0] d2, input logic [3:0] d1,
                                        input logic [3:0] d0);
      return (d2 == 4'd0) && (d1 == 4'd0) && (d0 == 4'd0);
   endfunction

endpackage

// File: rtl/countdown_display_seg7_decode.sv
// BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module seg7_decode
   import countdown_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   // Pure lookup, no state.
   always_comb begin
      seg = SEG_DASH;
      case (digit)
         4'd0: seg = 7'b1000000;
         4'd1: seg = 7'b1111001;
         4'd2: seg = 7'b0100100;
         4'd3: seg = 7'b0110000;
         4'd4: seg = 7'b0011001;
         4'd5: seg = 7'b0010010;
         4'd6: seg = 7'b0000010;
         4'd7: seg = 7'b1111000;
         4'd8: seg = 7'b0000000;
         4'd9: seg = 7'b0010000;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/countdown_display.sv
// Countdown display controller: drives three seven-segment digits from the
// countdown stage, blinks them in the last seconds, flashes dashes on expiry
// and freezes the remaining time when defused.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | not armed, live digits shown steady
// ST_RUN     | armed, live digits shown steady
// ST_WARN    | only ones digit left, live digits blink at BLINK_HALF rate
// ST_EXPIRED | time ran out or exploded, dashes blink until game_state idle
// ST_DEFUSED | digits latched on entry shown steady until game_state idle
//
// All outputs are registered and reflect the state being entered on the
// same edge, so an input digit change shows on hexN one cycle later.
module countdown_display
   import countdown_display_pkg::*;
#(
   parameter int BLINK_HALF = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] game_state,
   input  logic [3:0] value_three,
   input  logic [3:0] value_two,
   input  logic [3:0] value_one,
   output logic [6:0] hex2,
   output logic [6:0] hex1,
   output logic [6:0] hex0,
   output logic       warning,
   output logic       time_up
);

   localparam logic [BLINK_W-1:0] BLINK_LIM = BLINK_W'(BLINK_HALF - 1);

   state_t             state, state_nx;
   logic [BLINK_W-1:0] blink_cnt, blink_cnt_nx;
   logic               blink_off, blink_off_nx;
   logic [3:0]         lat2, lat1, lat0;
   logic [3:0]         lat2_nx, lat1_nx, lat0_nx;
   logic [3:0]         src2, src1, src0;
   logic [6:0]         seg2, seg1, seg0;
   logic [6:0]         hex2_nx, hex1_nx, hex0_nx;
   logic               expire_pulse;
   logic               all_zero, warn_digits;

   assign all_zero    = digits_zero(value_three, value_two, value_one);
   assign warn_digits = (value_three == 4'd0) && (value_two == 4'd0) && (value_one != 4'd0);

   // Next-state decision; defuse and external codes take priority over expiry.
   always_comb begin
      state_nx     = state;
      expire_pulse = 1'b0;
      case (state)
         ST_IDLE: begin
            if (game_state == GS_ARMED) state_nx = ST_RUN;
         end
         ST_RUN, ST_WARN: begin
            if (game_state == GS_DEFUSED)       state_nx = ST_DEFUSED;
            else if (game_state == GS_EXPLODED) state_nx = ST_EXPIRED;
            else if (game_state == GS_IDLE)     state_nx = ST_IDLE;
            else if (game_state == GS_ARMED && all_zero) begin
               state_nx     = ST_EXPIRED;
               expire_pulse = 1'b1;
            end
            else if (state == ST_RUN && warn_digits) state_nx = ST_WARN;
         end
         ST_EXPIRED, ST_DEFUSED: begin
            if (game_state == GS_IDLE) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Blink phase restarts visible on every state entry.
   always_comb begin
      blink_cnt_nx = blink_cnt + 1'b1;
      blink_off_nx = blink_off;
      if (state_nx != state) begin
         blink_cnt_nx = '0;
         blink_off_nx = 1'b0;
      end
      else if (blink_cnt == BLINK_LIM) begin
         blink_cnt_nx = '0;
         blink_off_nx = ~blink_off;
      end
   end

   // Capture the live digits on the edge that enters DEFUSED.
   always_comb begin
      lat2_nx = lat2;
      lat1_nx = lat1;
      lat0_nx = lat0;
      if (state_nx == ST_DEFUSED && state != ST_DEFUSED) begin
         lat2_nx = value_three;
         lat1_nx = value_two;
         lat0_nx = value_one;
      end
   end

   assign src2 = (state_nx == ST_DEFUSED) ? lat2_nx : value_three;
   assign src1 = (state_nx == ST_DEFUSED) ? lat1_nx : value_two;
   assign src0 = (state_nx == ST_DEFUSED) ? lat0_nx : value_one;

   seg7_decode u_dec2 (.digit(src2), .seg(seg2));
   seg7_decode u_dec1 (.digit(src1), .seg(seg1));
   seg7_decode u_dec0 (.digit(src0), .seg(seg0));

   // Segment selection for the state being entered.
   always_comb begin
      hex2_nx = SEG_BLANK;
      hex1_nx = SEG_BLANK;
      hex0_nx = SEG_BLANK;
      case (state_nx)
         ST_IDLE, ST_RUN, ST_DEFUSED: begin
            hex2_nx = seg2;
            hex1_nx = seg1;
            hex0_nx = seg0;
         end
         ST_WARN: begin
            hex2_nx = blink_off_nx ? SEG_BLANK : seg2;
            hex1_nx = blink_off_nx ? SEG_BLANK : seg1;
            hex0_nx = blink_off_nx ? SEG_BLANK : seg0;
         end
         ST_EXPIRED: begin
            hex2_nx = blink_off_nx ? SEG_BLANK : SEG_DASH;
            hex1_nx = blink_off_nx ? SEG_BLANK : SEG_DASH;
            hex0_nx = blink_off_nx ? SEG_BLANK : SEG_DASH;
         end
         default: begin
            hex2_nx = SEG_BLANK;
            hex1_nx = SEG_BLANK;
            hex0_nx = SEG_BLANK;
         end
      endcase
   end

   // State, blink timer, latched digits and all outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         blink_cnt <= '0;
         blink_off <= 1'b0;
         lat2      <= 4'd0;
         lat1      <= 4'd0;
         lat0      <= 4'd0;
         hex2      <= SEG_BLANK;
         hex1      <= SEG_BLANK;
         hex0      <= SEG_BLANK;
         warning   <= 1'b0;
         time_up   <= 1'b0;
      end
      else begin
         state     <= state_nx;
         blink_cnt <= blink_cnt_nx;
         blink_off <= blink_off_nx;
         lat2      <= lat2_nx;
         lat1      <= lat1_nx;
         lat0      <= lat0_nx;
         hex2      <= hex2_nx;
         hex1      <= hex1_nx;
         hex0      <= hex0_nx;
         warning   <= (state_nx == ST_WARN);
         time_up   <= expire_pulse;
      end
   end

endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display with BLINK_HALF=4: directed
// scenarios followed by randomized stimulus against a cycle-age reference model.
module tb_countdown_display;

   localparam int BH = 4;

   localparam int M_IDLE = 0, M_RUN = 1, M_WARN = 2, M_EXP = 3, M_DEF = 4;
   localparam logic [6:0] BLANK = 7'h7F;
   localparam logic [6:0] DASH  = 7'b0111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] game_state;
   logic [3:0] value_three, value_two, value_one;
   logic [6:0] hex2, hex1, hex0;
   logic       warning, time_up;

   countdown_display #(.BLINK_HALF(BH)) dut (
      .clk(clk), .reset(reset), .game_state(game_state),
      .value_three(value_three), .value_two(value_two), .value_one(value_one),
      .hex2(hex2), .hex1(hex1), .hex0(hex0),
      .warning(warning), .time_up(time_up)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, DASH, DASH, DASH, DASH, DASH, DASH};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   // Reference model: mode plus cycles spent in it; blink phase is age / BH.
   int         m_mode = M_IDLE;
   int         m_age  = 0;
   logic [3:0] m_lat [3];
   logic [6:0] e_hex2 = BLANK, e_hex1 = BLANK, e_hex0 = BLANK;
   logic       e_warn = 1'b0, e_tu = 1'b0;
   int         tu_count = 0;

   task automatic model_step();
      int  nm;
      bit  zero, wd, vis;
      if (reset) begin
         m_mode = M_IDLE; m_age = 0;
         m_lat[0] = 0; m_lat[1] = 0; m_lat[2] = 0;
         e_hex2 = BLANK; e_hex1 = BLANK; e_hex0 = BLANK;
         e_warn = 1'b0; e_tu = 1'b0;
         return;
      end
      nm   = m_mode;
      e_tu = 1'b0;
      zero = (value_three == 0) && (value_two == 0) && (value_one == 0);
      wd   = (value_three == 0) && (value_two == 0) && (value_one != 0);
      if (m_mode == M_IDLE) begin
         if (game_state == 8'h10) nm = M_RUN;
      end
      else if (m_mode == M_RUN || m_mode == M_WARN) begin
         if (game_state == 8'h20)      nm = M_DEF;
         else if (game_state == 8'h30) nm = M_EXP;
         else if (game_state == 8'h00) nm = M_IDLE;
         else if (game_state == 8'h10 && zero) begin nm = M_EXP; e_tu = 1'b1; end
         else if (m_mode == M_RUN && wd) nm = M_WARN;
      end
      else if (game_state == 8'h00) nm = M_IDLE;

      if (nm == M_DEF && m_mode != M_DEF) begin
         m_lat[2] = value_three; m_lat[1] = value_two; m_lat[0] = value_one;
      end
      m_age  = (nm == m_mode) ? m_age + 1 : 0;
      m_mode = nm;
      vis    = ((m_age / BH) % 2) == 0;
      e_warn = (m_mode == M_WARN);
      case (m_mode)
         M_DEF: begin
            e_hex2 = seg_tab[m_lat[2]]; e_hex1 = seg_tab[m_lat[1]]; e_hex0 = seg_tab[m_lat[0]];
         end
         M_EXP: begin
            e_hex2 = vis ? DASH : BLANK; e_hex1 = e_hex2; e_hex0 = e_hex2;
         end
         M_WARN: begin
            e_hex2 = vis ? seg_tab[value_three] : BLANK;
            e_hex1 = vis ? seg_tab[value_two]   : BLANK;
            e_hex0 = vis ? seg_tab[value_one]   : BLANK;
         end
         default: begin
            e_hex2 = seg_tab[value_three]; e_hex1 = seg_tab[value_two]; e_hex0 = seg_tab[value_one];
         end
      endcase
   endtask

   // One clock: edge, model update, sample 1 time unit later, full compare.
   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      if (time_up === 1'b1) tu_count++;
      check("cyc", {hex2, hex1, hex0, warning, time_up},
            {e_hex2, e_hex1, e_hex0, e_warn, e_tu});
   endtask

   task automatic drive(input logic [7:0] gs, input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0);
      game_state = gs; value_three = d2; value_two = d1; value_one = d0;
   endtask

   initial begin
      reset = 1'b1;
      drive(8'h00, 4'd2, 4'd0, 4'd0);
      cycle(); cycle();
      check("rst_hex", {hex2, hex1, hex0}, {BLANK, BLANK, BLANK});
      check("rst_flags", {warning, time_up}, 2'b00);
      reset = 1'b0;
      cycle();
      check("idle_200", {hex2, hex1, hex0}, {7'b0100100, 7'b1000000, 7'b1000000});

      // Warning blink on ones digit 9.
      drive(8'h10, 4'd0, 4'd1, 4'd0);
      cycle(); cycle();
      check("run_warn0", warning, 1'b0);
      drive(8'h10, 4'd0, 4'd0, 4'd9);
      for (int i = 0; i < 12; i++) begin
         cycle();
         check("warn_flag", warning, 1'b1);
         check("warn_blink", hex0, ((i / 4) % 2 == 0) ? 7'b0010000 : BLANK);
      end

      // Reset in WARN.
      reset = 1'b1;
      cycle();
      check("warn_rst_hex", {hex2, hex1, hex0}, {BLANK, BLANK, BLANK});
      check("warn_rst_flag", warning, 1'b0);
      reset = 1'b0;
      drive(8'h00, 4'd0, 4'd0, 4'd9);
      cycle(); cycle();
      check("post_rst_idle", {warning, hex0}, {1'b0, 7'b0010000});

      // Expiry: one pulse, dash blink, no repeat while held.
      drive(8'h10, 4'd0, 4'd0, 4'd1);
      cycle(); cycle();
      drive(8'h10, 4'd0, 4'd0, 4'd0);
      tu_count = 0;
      cycle();
      check("tu_pulse", time_up, 1'b1);
      check("exp_dash", {hex2, hex1, hex0}, {DASH, DASH, DASH});
      for (int i = 1; i <= 12; i++) begin
         cycle();
         check("exp_blink", hex1, ((i / 4) % 2 == 0) ? DASH : BLANK);
      end
      check("tu_once", tu_count, 1);
      drive(8'h00, 4'd0, 4'd0, 4'd0);
      cycle();

      // Defuse races expiry; display frozen.
      drive(8'h10, 4'd0, 4'd0, 4'd1);
      cycle(); cycle();
      drive(8'h20, 4'd0, 4'd0, 4'd0);
      cycle();
      check("def_no_tu", time_up, 1'b0);
      drive(8'h20, 4'd2, 4'd0, 4'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("def_frozen", {hex2, hex1, hex0}, {7'b1000000, 7'b1000000, 7'b1000000});
      end
      drive(8'h00, 4'hC, 4'd1, 4'd2);
      cycle(); cycle();
      check("dash_code_c", hex2, DASH);

      // Randomized stimulus.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 5))
               0: game_state = 8'h00;
               1: game_state = 8'h20;
               2: game_state = 8'h30;
               default: game_state = 8'h10;
            endcase
         end
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0: begin value_three = 0; value_two = 0; value_one = 0; end
               1: begin value_three = 0; value_two = 0; value_one = 4'($urandom_range(0, 15)); end
               default: begin
                  value_three = 4'($urandom_range(0, 15));
                  value_two   = 4'($urandom_range(0, 15));
                  value_one   = 4'($urandom_range(0, 15));
               end
            endcase
         end
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 Parameter BLINK_HALF, default 12500000, blink half-period in clk cycles (0.25 s at 50 MHz); legal range 2..2^24-1.
REQ-002 clk  in  1  sole clock, on-board 50 MHz; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 game_state  in  8  controller state: 8'h00 idle, 8'h10 armed/counting, 8'h20 defused, 8'h30 exploded.
REQ-005 value_three, value_two, value_one  in  4 each  BCD time digits from the countdown stage, left to right.
REQ-006 hex2, hex1, hex0  out  7 each  active-low segments {g,f,e,d,c,b,a}, bit0 = a; hex2 leftmost.
REQ-007 warning  out  1  high while in WARN.
REQ-008 time_up  out  1  one-cycle pulse when the count reaches 000 while armed.

Function
REQ-009 All outputs SHALL be registered; a digit change SHALL appear on hexN exactly 1 cycle later.
REQ-010 FSM states SHALL be IDLE, RUN, WARN, EXPIRED, DEFUSED.
REQ-011 IDLE: live digits steady; go to RUN when game_state==8'h10.
REQ-012 RUN: live digits steady; go to WARN when value_three==0, value_two==0, value_one!=0.
REQ-013 RUN/WARN: digits 000 with game_state==8'h10 SHALL go to EXPIRED and pulse time_up for exactly one cycle.
REQ-014 RUN/WARN: game_state==8'h20 -> DEFUSED; 8'h30 -> EXPIRED without time_up; 8'h00 -> IDLE.
REQ-015 Simultaneous 000 and game_state==8'h20: DEFUSED wins, no time_up.
REQ-016 WARN: displays visible for BLINK_HALF cycles then blanked (7'h7F) for BLINK_HALF cycles, repeating; first phase after entry is visible.
REQ-017 Blink counter SHALL clear on every state entry; wrap at BLINK_HALF-1.
REQ-018 EXPIRED: all three displays alternate dash (7'b0111111) and blank at BLINK_HALF rate; leave to IDLE only on game_state==8'h00.
REQ-019 DEFUSED: digits latched on entry, shown steady regardless of later input changes; leave to IDLE only on game_state==8'h00.
REQ-020 Decode: 0..9 standard patterns (0=7'b1000000, 2=7'b0100100, 8=7'b0000000, 9=7'b0010000); 10..15 SHALL show dash.
REQ-021 warning SHALL be 1 in WARN only; time_up SHALL never assert twice without passing through IDLE.

Reset
REQ-022 On reset: state IDLE, blink counter 0, latched digits 0, warning 0, time_up 0, hex2/hex1/hex0 = 7'h7F (blank).
REQ-023 reset asserted mid-operation (any state) SHALL override all inputs in that cycle; first post-reset decision uses current inputs.

Structure
REQ-024 Shared package SHALL hold game_state codes (8'h00/10/20/30), FSM state encoding, and SEG_BLANK/SEG_DASH constants.
REQ-025 One sub-module seg7_decode (4-bit BCD in, 7-bit active-low out, purely combinational), instantiated three times.
REQ-026 Blink counter width SHALL be 24 bits.

Verification (BLINK_HALF=4)
REQ-027 Reset, digits 2/0/0, game_state 8'h00 -> hex2=7'b0100100, hex1=hex0=7'b1000000 one cycle after reset release.
REQ-028 game_state 8'h10, digits 0/1/0 then 0/0/9 -> warning=1; hex0 pattern 9 for 4 cycles, 7'h7F for 4, repeating.
REQ-029 Armed, digits step 0/0/1 -> 0/0/0 -> time_up high exactly 1 cycle; displays alternate dash/blank every 4 cycles; no second pulse while held.
REQ-030 Armed at 0/0/1, next cycle digits 0/0/0 with game_state 8'h20 -> DEFUSED, time_up stays 0, display frozen at 000 while inputs then change to 2/0/0.
REQ-031 In WARN, assert reset for 1 cycle -> all hex = 7'h7F, warning=0; with game_state 8'h00 stays IDLE.
REQ-032 Digit input 4'hC in IDLE -> corresponding display = 7'b0111111.
